anim_sequencer: RTL and testbench
=================================

Name: anim_sequencer

Overview:
Upstream stage that generates the 4-bit mode code consumed by the cat/dog/mouse frame register stage. Code format: mode[3:2] selects the animal (00 cat, 01 dog, 10 mouse); mode[1:0] selects the frame (00 rest, 01..11 frames 1..3). The block plays frame loops for one animal, or round-robin over all three, with start/stop/pause control. When not playing it drives 4'b1111, a code the downstream stage treats as hold.

Parameters:
LOOPS, 2, number of full frame loops per animal before completion; 0 = run until stop
LOOP_W, 4, loop counter width; LOOPS must be < 2^LOOP_W

Ports:
clk1hz  input  1  frame clock; all inputs sampled on its rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  begin playback; honoured only in IDLE
stop  input  1  abort playback
pause  input  1  level; freezes playback while high
sel  input  2  animal select latched at start: 00 cat, 01 dog, 10 mouse, 11 round-robin cat->dog->mouse
dir  input  1  latched at start: 0 forward (frames 1,2,3,0), 1 reverse (frames 3,2,1,0)
mode  output  4  registered mode code to the frame stage
busy  output  1  high in RUN, PAUSE and FINISH
done  output  1  one-cycle pulse on normal completion

Behaviour:
- Reset (async): state=IDLE; mode=4'b1111; busy=0; done=0; frame, animal and loop counters=0.
- States: IDLE, RUN, PAUSE, FINISH. All outputs are registered. Latency is one clk1hz edge from sampled input to mode change.
- IDLE: mode=1111.
  - start=1 and stop=0: latch sel and dir; animal = sel (cat if sel=11); loop=0; mode<={animal, first frame} (01 forward, 11 reverse); go RUN.
  - start ignored in every non-IDLE state. stop in IDLE: no effect.
- RUN, per edge:
  - Priority: stop > pause > step.
  - Step: emit the next frame in dir order. The loop ends on the edge that emits frame 00.
  - On the edge after a loop-ending 00: loop++ (saturating at 2^LOOP_W-1).
  - If LOOPS!=0 and loop reaches LOOPS:
    - Round-robin and animal!=mouse: advance animal, loop=0, emit first frame.
    - Otherwise: mode<=1111, done<=1, go FINISH.
  - Else: emit first frame of the next loop.
- PAUSE (entered when pause=1 in RUN): mode<=1111 each cycle; frame, loop and animal frozen. When pause=0, emit the next frame the frozen sequence would have emitted and return to RUN.
- Stop in RUN or PAUSE: mode<={animal,00} (returns the animal to rest); flag aborted; go FINISH. done is not asserted.
- FINISH: one cycle. mode<=1111; done<=0 (done high during FINISH only on normal completion); busy<=0; go IDLE.
- LOOPS=0: loops forever.
  - Round-robin advances animal after every loop, wrapping mouse->cat.
  - Loop counter saturates; only stop exits.
- Simultaneous events:
  - start+stop in IDLE: stay IDLE.
  - pause+stop: stop wins.
  - pause asserted on the first RUN edge: that emitted frame stands; freeze from the next edge.
- sel/dir changes while busy are ignored until the next start.
- rst mid-run: immediate return to reset values. The frame stage is reset by the same rst.
- Invariant: mode never carries mode[3:2]=11 except the code 1111.

Test Plan:
- Reset, then start with sel=00, dir=0, LOOPS=2 -> mode sequence 0001,0010,0011,0000,0001,0010,0011,0000,1111, then idle 1111; done=1 for the single cycle mode=1111 after the run; busy high from first 0001 until that cycle.
- sel=11, dir=1, LOOPS=1 -> 0011,0010,0001,0000,0111,0110,0101,0100,1011,1010,1001,1000,1111 with done pulse.
- sel=01, dir=0, pause high for 3 cycles after 0110 -> 0101,0110,1111,1111,1111,0111,0100,... ; no frame skipped or repeated.
- sel=10 running, stop asserted after 1010 -> next mode 1000, then 1111; done stays 0; busy drops; a new start is accepted one cycle later.
- start while busy, and start+stop in IDLE -> no sequence restart, no state change; mode stays 1111 when idle.
- rst pulse mid-sequence (async, between edges) -> mode=1111, busy=0, done=0 immediately; LOOPS=0 run with sel=00 continues past 20 loops until stop.

Source files
------------

// File: rtl/anim_sequencer.sv
// Frame-loop sequencer producing the 4-bit animal/frame mode code for the frame register stage.
// State | meaning: IDLE hold (1111) | RUN stepping frames | PAUSE frozen, emits 1111 | FINISH one-cycle wrap-up
module anim_sequencer #(
    parameter int LOOPS  = 2,
    parameter int LOOP_W = 4
) (
    input  logic       clk1hz,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic [1:0] sel,
    input  logic       dir,
    output logic [3:0] mode,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, FINISH} state_t;

    localparam logic [3:0]        HOLD     = 4'b1111;
    localparam logic [1:0]        MOUSE    = 2'b10;
    localparam logic [LOOP_W-1:0] LOOP_MAX = '1;
    localparam logic [LOOP_W-1:0] LOOPS_V  = LOOP_W'(LOOPS);

    state_t            state, state_n;
    logic [1:0]        frame, frame_n;
    logic [1:0]        animal, animal_n;
    logic [LOOP_W-1:0] loop, loop_n;
    logic              rr, rr_n;
    logic              dir_q, dir_n;
    logic [3:0]        mode_n;
    logic              busy_n, done_n;

    logic [1:0]        first_frame;
    logic [1:0]        step_frame, step_animal;
    logic [LOOP_W-1:0] step_loop, loop_inc;
    logic              step_fin;

    always_ff @(posedge clk1hz or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            frame  <= 2'b00;
            animal <= 2'b00;
            loop   <= '0;
            rr     <= 1'b0;
            dir_q  <= 1'b0;
            mode   <= HOLD;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            frame  <= frame_n;
            animal <= animal_n;
            loop   <= loop_n;
            rr     <= rr_n;
            dir_q  <= dir_n;
            mode   <= mode_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        frame_n     = frame;
        animal_n    = animal;
        loop_n      = loop;
        rr_n        = rr;
        dir_n       = dir_q;
        mode_n      = mode;
        busy_n      = busy;
        done_n      = 1'b0;

        // Next element of the playing sequence, shared by RUN and the PAUSE resume path.
        first_frame = dir_q ? 2'b11 : 2'b01;
        loop_inc    = (loop == LOOP_MAX) ? loop : loop + 1'b1;
        step_fin    = 1'b0;
        step_animal = animal;
        step_loop   = loop;
        step_frame  = dir_q ? frame - 2'd1 : frame + 2'd1;
        if (frame == 2'b00) begin
            step_loop  = loop_inc;
            step_frame = first_frame;
            if (LOOPS != 0 && loop_inc == LOOPS_V) begin
                if (rr && animal != MOUSE) begin
                    step_animal = animal + 2'd1;
                    step_loop   = '0;
                end else begin
                    step_fin = 1'b1;
                end
            end else if (LOOPS == 0 && rr) begin
                step_animal = (animal == MOUSE) ? 2'b00 : animal + 2'd1;
            end
        end

        case (state)
            IDLE: begin
                mode_n = HOLD;
                busy_n = 1'b0;
                if (start && !stop) begin
                    rr_n     = (sel == 2'b11);
                    dir_n    = dir;
                    animal_n = (sel == 2'b11) ? 2'b00 : sel;
                    loop_n   = '0;
                    frame_n  = dir ? 2'b11 : 2'b01;
                    mode_n   = {animal_n, frame_n};
                    busy_n   = 1'b1;
                    state_n  = RUN;
                end
            end
            RUN, PAUSE: begin
                if (stop) begin
                    mode_n  = {animal, 2'b00};
                    state_n = FINISH;
                end else if (pause) begin
                    mode_n  = HOLD;
                    state_n = PAUSE;
                end else if (step_fin) begin
                    mode_n  = HOLD;
                    done_n  = 1'b1;
                    state_n = FINISH;
                end else begin
                    frame_n  = step_frame;
                    loop_n   = step_loop;
                    animal_n = step_animal;
                    mode_n   = {step_animal, step_frame};
                    state_n  = RUN;
                end
            end
            FINISH: begin
                mode_n  = HOLD;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                mode_n  = HOLD;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_anim_sequencer.sv
// Bench for anim_sequencer: three instances (LOOPS=2,1,0) against a playlist-index model plus literal sequences.
module tb_anim_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start, stop, pause;
    logic [1:0] sel;
    logic       dir;
    logic [3:0] mode [3];
    logic       busy [3];
    logic       done [3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    anim_sequencer #(.LOOPS(2), .LOOP_W(4)) u0 (.clk1hz(clk), .rst(rst), .start(start[0]), .stop(stop[0]),
        .pause(pause[0]), .sel(sel), .dir(dir), .mode(mode[0]), .busy(busy[0]), .done(done[0]));
    anim_sequencer #(.LOOPS(1), .LOOP_W(4)) u1 (.clk1hz(clk), .rst(rst), .start(start[1]), .stop(stop[1]),
        .pause(pause[1]), .sel(sel), .dir(dir), .mode(mode[1]), .busy(busy[1]), .done(done[1]));
    anim_sequencer #(.LOOPS(0), .LOOP_W(4)) u2 (.clk1hz(clk), .rst(rst), .start(start[2]), .stop(stop[2]),
        .pause(pause[2]), .sel(sel), .dir(dir), .mode(mode[2]), .busy(busy[2]), .done(done[2]));

    // Model: playback is an index into the flattened playlist animal x loop x frame.
    int         m_phase [3];
    int         m_idx   [3];
    logic [1:0] m_sel   [3];
    logic       m_dir   [3];
    logic [3:0] e_mode  [3];
    logic       e_busy  [3];
    logic       e_done  [3];

    function automatic int lp(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 0);
    endfunction

    function automatic logic [1:0] animal_of(input int k, input int idx);
        if (m_sel[k] != 2'b11) return m_sel[k];
        if (lp(k) == 0) return 2'((idx / 4) % 3);
        return 2'(idx / (4 * lp(k)));
    endfunction

    function automatic logic [3:0] code(input int k, input int idx);
        int f;
        f = m_dir[k] ? 3 - (idx % 4) : ((idx % 4) + 1) % 4;
        return {animal_of(k, idx), 2'(f)};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                m_phase[k] = 0; m_idx[k] = 0; m_sel[k] = 2'b00; m_dir[k] = 1'b0;
                e_mode[k] = 4'hF; e_busy[k] = 1'b0; e_done[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                case (m_phase[k])
                    0: begin
                        e_mode[k] = 4'hF; e_busy[k] = 1'b0; e_done[k] = 1'b0;
                        if (start[k] && !stop[k]) begin
                            m_sel[k] = sel; m_dir[k] = dir; m_idx[k] = 0;
                            e_mode[k] = code(k, 0); e_busy[k] = 1'b1; m_phase[k] = 1;
                        end
                    end
                    1: begin
                        if (stop[k]) begin
                            e_mode[k] = {animal_of(k, m_idx[k]), 2'b00};
                            m_phase[k] = 2;
                        end else if (pause[k]) begin
                            e_mode[k] = 4'hF;
                        end else begin
                            m_idx[k] = m_idx[k] + 1;
                            if (lp(k) != 0 && m_idx[k] == lp(k) * 4 * ((m_sel[k] == 2'b11) ? 3 : 1)) begin
                                e_mode[k] = 4'hF; e_done[k] = 1'b1; m_phase[k] = 2;
                            end else begin
                                e_mode[k] = code(k, m_idx[k]);
                            end
                        end
                    end
                    default: begin
                        e_mode[k] = 4'hF; e_busy[k] = 1'b0; e_done[k] = 1'b0; m_phase[k] = 0;
                    end
                endcase
            end
        end
    end

    task automatic chk(input string name, input int k, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t got=%h want=%h", name, k, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk("cmp_mode", k, mode[k], e_mode[k]);
            chk("cmp_busy", k, {3'b0, busy[k]}, {3'b0, e_busy[k]});
            chk("cmp_done", k, {3'b0, done[k]}, {3'b0, e_done[k]});
            chk("invariant", k, {3'b0, (mode[k][3:2] == 2'b11 && mode[k] != 4'hF)}, 4'h0);
        end
    end

    // Directed table: entry i is checked at a negedge, then the row's controls are driven.
    logic [3:0]  t_mode [16];
    logic [15:0] t_start, t_stop, t_pause, t_busy, t_done;

    task automatic run_seq(input string name, input int k, input int n, input int chg);
        for (int i = 0; i < n; i++) begin
            chk({name, "_mode"}, k, mode[k], t_mode[i]);
            chk({name, "_model"}, k, e_mode[k], t_mode[i]);
            chk({name, "_busy"}, k, {3'b0, busy[k]}, {3'b0, t_busy[i]});
            chk({name, "_done"}, k, {3'b0, done[k]}, {3'b0, t_done[i]});
            if (i == chg) begin sel = 2'b10; dir = 1'b1; end
            start[k] = t_start[i]; stop[k] = t_stop[i]; pause[k] = t_pause[i];
            @(negedge clk);
        end
        start[k] = 1'b0; stop[k] = 1'b0; pause[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = '0; stop = '0; pause = '0; sel = 2'b00; dir = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_mode", k, mode[k], 4'hF);
            chk("reset_busy", k, {3'b0, busy[k]}, 4'h0);
            chk("reset_done", k, {3'b0, done[k]}, 4'h0);
        end
        rst = 1'b0;
        @(negedge clk);

        // cat forward, two loops
        sel = 2'b00; dir = 1'b0;
        t_mode = '{4'hF,4'h1,4'h2,4'h3,4'h0,4'h1,4'h2,4'h3,4'h0,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF};
        t_start = 16'h0001; t_stop = 16'h0000; t_pause = 16'h0000; t_busy = 16'h03FE; t_done = 16'h0200;
        run_seq("cat_fwd", 0, 11, -1);

        // round-robin reverse, one loop each
        sel = 2'b11; dir = 1'b1;
        t_mode = '{4'hF,4'h3,4'h2,4'h1,4'h0,4'h7,4'h6,4'h5,4'h4,4'hB,4'hA,4'h9,4'h8,4'hF,4'hF,4'hF};
        t_start = 16'h0001; t_stop = 16'h0000; t_pause = 16'h0000; t_busy = 16'h3FFE; t_done = 16'h2000;
        run_seq("rr_rev", 1, 15, -1);

        // dog with a three-cycle pause after 0110
        sel = 2'b01; dir = 1'b0;
        t_mode = '{4'hF,4'h5,4'h6,4'hF,4'hF,4'hF,4'h7,4'h4,4'h5,4'h6,4'h7,4'h4,4'hF,4'hF,4'hF,4'hF};
        t_start = 16'h0001; t_stop = 16'h0000; t_pause = 16'h001C; t_busy = 16'h1FFE; t_done = 16'h1000;
        run_seq("dog_pause", 0, 14, -1);

        // mouse stopped after 1010, restart the cycle after busy drops, stop again
        sel = 2'b10; dir = 1'b0;
        t_mode = '{4'hF,4'h9,4'hA,4'h8,4'hF,4'h9,4'h8,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF};
        t_start = 16'h0011; t_stop = 16'h0024; t_pause = 16'h0000; t_busy = 16'h006E; t_done = 16'h0000;
        run_seq("mouse_stop", 0, 9, -1);

        // start+stop in idle, start while busy, sel/dir change while busy
        sel = 2'b00; dir = 1'b0;
        t_mode = '{4'hF,4'hF,4'h1,4'h2,4'h3,4'h0,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF};
        t_start = 16'h000F; t_stop = 16'h0011; t_pause = 16'h0000; t_busy = 16'h003C; t_done = 16'h0000;
        run_seq("start_ign", 0, 8, 2);

        // pause together with the start edge: first frame stands
        sel = 2'b00; dir = 1'b1;
        t_mode = '{4'hF,4'h3,4'hF,4'h2,4'h1,4'h0,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF,4'hF};
        t_start = 16'h0001; t_stop = 16'h0000; t_pause = 16'h0003; t_busy = 16'h007E; t_done = 16'h0040;
        run_seq("pause_first", 1, 8, -1);

        // async reset mid-run
        sel = 2'b00; dir = 1'b0;
        start[2] = 1'b1; @(negedge clk); start[2] = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_async_mode", k, mode[k], 4'hF);
            chk("rst_async_busy", k, {3'b0, busy[k]}, 4'h0);
            chk("rst_async_done", k, {3'b0, done[k]}, 4'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // endless cat loop runs past 20 loops until stop
        start[2] = 1'b1; @(negedge clk); start[2] = 1'b0;
        chk("inf_first", 2, mode[2], 4'h1);
        repeat (88) @(negedge clk);
        chk("inf_22loops_mode", 2, mode[2], 4'h1);
        chk("inf_22loops_busy", 2, {3'b0, busy[2]}, 4'h1);
        stop[2] = 1'b1; @(negedge clk); stop[2] = 1'b0;
        chk("inf_stop_rest", 2, mode[2], 4'h0);
        @(negedge clk);
        chk("inf_stop_idle", 2, mode[2], 4'hF);
        chk("inf_stop_busy", 2, {3'b0, busy[2]}, 4'h0);

        // endless round-robin wraps mouse->cat; stop+pause together, stop wins
        sel = 2'b11; dir = 1'b0;
        t_mode = '{4'hF,4'h1,4'h2,4'h3,4'h0,4'h5,4'h6,4'h7,4'h4,4'h9,4'hA,4'hB,4'h8,4'h1,4'h0,4'hF};
        t_start = 16'h0001; t_stop = 16'h2000; t_pause = 16'h2000; t_busy = 16'h7FFE; t_done = 16'h0000;
        run_seq("rr_inf", 2, 16, -1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
